// File: rtl/mem_rd_skew_ctrl.sv
// mem_rd_skew_ctrl: diagonally skewed scratchpad read sequencer.
// Define MEM_RD_SKEW_EN for per-bank skew; undefined reads all banks in lockstep.
module mem_rd_skew_ctrl #(
    parameter int SYS_ROW    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] num_row,
    input  logic                  stall,
    output logic [SYS_ROW-1:0]    rd_en_out,
    output logic [ADDR_WIDTH-1:0] rd_addr [0:SYS_ROW-1],
    output logic                  rd_busy,
    output logic                  rd_done
);

    localparam int TW = DATA_WIDTH + $clog2(SYS_ROW) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] base_d;
    logic [DATA_WIDTH-1:0] nrow_q;
    logic [DATA_WIDTH-1:0] nrow_d;
    logic [TW-1:0]         t_q;
    logic [TW-1:0]         t_d;
    logic [TW-1:0]         nsteps;
    logic [TW-1:0]         it;
    logic                  issue;
    logic                  hold;
    logic                  busy_d;
    logic                  done_d;
    logic [SYS_ROW-1:0]    en_d;
    logic [ADDR_WIDTH-1:0] addr_d [0:SYS_ROW-1];

    // Total number of issue steps for the latched job.
`ifdef MEM_RD_SKEW_EN
    assign nsteps = TW'(nrow_q) + TW'(SYS_ROW - 1);
`else
    assign nsteps = TW'(nrow_q);
`endif

    // Next-state, step counter and job latch; t counts steps already issued.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        nrow_d  = nrow_q;
        t_d     = t_q;
        it      = '0;
        issue   = 1'b0;
        hold    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_start) begin
                    base_d = base_addr;
                    nrow_d = num_row;
                    t_d    = '0;
                    if (num_row == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        issue   = 1'b1;
                        t_d     = TW'(1);
                    end
                end
            end
            RUN: begin
                if (t_q == nsteps) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (stall) begin
                    busy_d = 1'b1;
                    hold   = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    issue  = 1'b1;
                    it     = t_q;
                    t_d    = t_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-bank enable/address for the step being issued this edge.
    always_comb begin
        for (int i = 0; i < SYS_ROW; i++) begin
            en_d[i]   = 1'b0;
            addr_d[i] = '0;
            if (issue) begin
`ifdef MEM_RD_SKEW_EN
                if (it >= TW'(i) && it < TW'(nrow_d) + TW'(i)) begin
                    en_d[i]   = 1'b1;
                    addr_d[i] = base_d + it[ADDR_WIDTH-1:0]
                              - ADDR_WIDTH'(i);
                end
`else
                if (it < TW'(nrow_d)) begin
                    en_d[i]   = 1'b1;
                    addr_d[i] = base_d + it[ADDR_WIDTH-1:0];
                end
`endif
            end else if (hold) begin
                addr_d[i] = rd_addr[i];
            end
        end
    end

    // Control state and job registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            base_q  <= '0;
            nrow_q  <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            nrow_q  <= nrow_d;
            t_q     <= t_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_en_out <= '0;
            rd_busy   <= 1'b0;
            rd_done   <= 1'b0;
            for (int i = 0; i < SYS_ROW; i++) begin
                rd_addr[i] <= '0;
            end
        end else begin
            rd_en_out <= en_d;
            rd_busy   <= busy_d;
            rd_done   <= done_d;
            for (int i = 0; i < SYS_ROW; i++) begin
                rd_addr[i] <= addr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_rd_skew_ctrl.sv
// tb_mem_rd_skew_ctrl: randomized jobs against a row-schedule model.
// Build with or without MEM_RD_SKEW_EN to match the design.
module tb_mem_rd_skew_ctrl;

    localparam int SR = 16;
    localparam int DW = 16;
    localparam int AW = 8;
`ifdef MEM_RD_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rd_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] num_row = '0;
    logic          stall = 1'b0;
    logic [SR-1:0] rd_en_out;
    logic [AW-1:0] rd_addr [0:SR-1];
    logic          rd_busy;
    logic          rd_done;

    mem_rd_skew_ctrl #(
        .SYS_ROW   (SR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_start (rd_start),
        .base_addr(base_addr),
        .num_row  (num_row),
        .stall    (stall),
        .rd_en_out(rd_en_out),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .rd_done  (rd_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: mode 0 idle, 1 job open, 2 done shown
    int            cyc = 0;
    int            m_mode = 0;
    int            m_k = 0;
    int            m_n = 0;
    int            m_total = 0;
    int            m_s = 0;
    logic [AW-1:0] m_base = '0;
    logic [SR-1:0] exp_en = '0;
    logic [AW-1:0] exp_addr [0:SR-1];
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    bit            run_chk = 1'b0;

    // measurements from the DUT
    bit            done_seen;
    int            done_rel;
    int            first15;
    int            en_total;
    logic [AW-1:0] q15 [$];

    task automatic zero_out();
        exp_en = '0;
        for (int i = 0; i < SR; i++) exp_addr[i] = '0;
    endtask

    // step k reads row (k - i) on bank i when skewed, row k otherwise
    task automatic issue(input int k);
        int row;
        for (int i = 0; i < SR; i++) begin
            row = SKEW ? k - i : k;
            if (row >= 0 && row < m_n) begin
                exp_en[i]   = 1'b1;
                exp_addr[i] = m_base + AW'(row);
            end else begin
                exp_en[i]   = 1'b0;
                exp_addr[i] = '0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            m_mode   = 0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            zero_out();
        end else begin
            case (m_mode)
                0: begin
                    exp_done = 1'b0;
                    exp_busy = 1'b0;
                    zero_out();
                    if (rd_start) begin
                        m_base  = base_addr;
                        m_n     = int'(num_row);
                        m_s     = cyc;
                        m_total = SKEW ? m_n + SR - 1 : m_n;
                        if (m_n == 0) begin
                            exp_done = 1'b1;
                            m_mode   = 2;
                        end else begin
                            issue(0);
                            m_k      = 1;
                            exp_busy = 1'b1;
                            m_mode   = 1;
                        end
                    end
                end
                1: begin
                    if (m_k == m_total) begin
                        zero_out();
                        exp_busy = 1'b0;
                        exp_done = 1'b1;
                        m_mode   = 2;
                    end else if (stall) begin
                        exp_en   = '0;
                        exp_busy = 1'b1;
                    end else begin
                        issue(m_k);
                        m_k++;
                    end
                end
                default: begin
                    zero_out();
                    exp_busy = 1'b0;
                    exp_done = 1'b0;
                    m_mode   = 0;
                end
            endcase
        end
        cyc++;
        run_chk = 1'b1;
    end

    // per-cycle comparison and measurement
    always @(negedge clk) begin
        if (run_chk) begin
            int bad;
            bad = -1;
            for (int i = 0; i < SR; i++)
                if (rd_addr[i] !== exp_addr[i] && bad < 0) bad = i;
            checks++;
            if (rd_en_out !== exp_en || rd_busy !== exp_busy ||
                rd_done !== exp_done || bad >= 0) begin
                errors++;
                $display("FAIL cycle %0d: en %h/%h busy %b/%b done %b/%b bad_addr_bank %0d (got/exp)",
                         cyc, rd_en_out, exp_en, rd_busy, exp_busy,
                         rd_done, exp_done, bad);
            end
            if (rd_done === 1'b1) begin
                done_seen = 1'b1;
                done_rel  = cyc - m_s;
            end
            if (rd_en_out[SR-1] === 1'b1) begin
                if (first15 < 0) first15 = cyc - m_s;
                q15.push_back(rd_addr[SR-1]);
            end
            en_total += $countones(rd_en_out);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_meas();
        done_seen = 1'b0;
        done_rel  = -1;
        first15   = -1;
        en_total  = 0;
        q15.delete();
    endtask

    // rnd: random stall and spurious starts; otherwise stall in cycles
    // st_from..st_from+st_len-1 (visible one cycle later), start pulse at spur_at
    task automatic run_job(input logic [AW-1:0] b, input int n,
                           input int st_from, input int st_len,
                           input int spur_at, input bit rnd);
        int rel;
        clear_meas();
        @(posedge clk);
        #2;
        rd_start  = 1'b1;
        base_addr = b;
        num_row   = DW'(n);
        @(posedge clk);
        #2;
        rd_start  = 1'b0;
        rel = 1;
        while (!done_seen) begin
            if (rnd) begin
                stall     = ($urandom_range(0, 3) == 0);
                rd_start  = ($urandom_range(0, 9) == 0);
                base_addr = AW'($urandom_range(0, 255));
                num_row   = DW'($urandom_range(0, 7));
            end else begin
                stall    = (rel >= st_from && rel < st_from + st_len);
                rd_start = (rel == spur_at);
                if (rel == spur_at) begin
                    base_addr = 8'h99;
                    num_row   = 16'd3;
                end
            end
            @(posedge clk);
            #2;
            rel++;
            if (rel > 400) begin
                errors++;
                $display("FAIL timeout: no rd_done after %0d cycles", rel);
                break;
            end
        end
        stall    = 1'b0;
        rd_start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        clear_meas();
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        run_job(8'h10, 4, 0, 0, -1, 1'b0);
        chk("jobA_done_cycle", done_rel, SKEW ? 20 : 5);
        chk("jobA_bank15_first", first15, SKEW ? 16 : 1);
        chk("jobA_enable_count", en_total, SR * 4);
        chk("jobA_bank15_rows", q15.size(), 4);
        if (q15.size() == 4) chk("jobA_bank15_last_addr", int'(q15[3]), 8'h13);

        run_job(8'hFE, 3, 0, 0, -1, 1'b0);
        chk("wrap_rows", q15.size(), 3);
        if (q15.size() == 3) begin
            chk("wrap_addr0", int'(q15[0]), 8'hFE);
            chk("wrap_addr1", int'(q15[1]), 8'hFF);
            chk("wrap_addr2", int'(q15[2]), 8'h00);
        end

        run_job(8'h00, 2, 2, 3, -1, 1'b0);
        chk("stall_done_cycle", done_rel, SKEW ? 21 : 3);
        chk("stall_enable_count", en_total, SR * 2);

        run_job(8'h55, 0, 0, 0, -1, 1'b0);
        chk("zero_done_cycle", done_rel, 1);
        chk("zero_enable_count", en_total, 0);

        run_job(8'h40, 8, 0, 0, 4, 1'b0);
        chk("ignored_start_done", done_rel, SKEW ? 24 : 9);
        chk("ignored_start_enables", en_total, SR * 8);

        clear_meas();
        @(posedge clk);
        #2;
        rd_start  = 1'b1;
        base_addr = 8'h30;
        num_row   = 16'd8;
        @(posedge clk);
        #2;
        rd_start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (SR + 10) @(posedge clk);
        chk("reset_abort_no_done", int'(done_seen), 0);

        run_job(8'h05, 3, 0, 0, -1, 1'b0);
        chk("after_reset_done", done_rel, SKEW ? 19 : 4);

        for (int j = 0; j < 30; j++) begin
            run_job(AW'($urandom_range(0, 255)), $urandom_range(0, 6),
                    0, 0, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
